// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the registered N-channel scan multiplexer.
// Mode encodings, the two-state FSM enum and a width helper that never returns 0.
package mux_scan_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_SCAN   = 1'b1
  } state_e;

  // $clog2 of 1 or 2 would give 0 or 1; clamp so a 1-bit select/counter is always legal.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_scan_n_dwell_counter.sv
// Dwell counter for scan mode: counts enabled cycles on the current channel
// and flags the last one. Always wraps to 0, never saturates.
module dwell_counter
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = clog2_min1(DWELL + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = en && (cnt_q == CW'(DWELL - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mux_scan_n.sv
// Registered N-channel multiplexer with manual select and automatic scan.
// Output handshake: valid qualifies dout/ch each cycle; there is no ready, the sink takes every valid cycle.
module mux_scan_n
  import mux_scan_pkg::*;
#(
  parameter  int WIDTH    = 1,
  parameter  int CHANNELS = 4,
  parameter  int DWELL    = 4,
  localparam int SELW     = clog2_min1(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic                      mode,
  input  logic [SELW-1:0]           sel,
  input  logic                      en,
  output logic [WIDTH-1:0]          dout,
  output logic [SELW-1:0]           ch,
  output logic                      valid,
  output logic                      wrap,
  output state_e                    state_dbg
);

  state_e            state_q;
  logic [SELW-1:0]   ch_q;
  logic [WIDTH-1:0]  dout_q;
  logic              valid_q;
  logic              wrap_q;

  logic              scan_live;
  logic              last_ch;
  logic              tick;
  logic              in_range;
  logic [SELW-1:0]   ch_d;
  logic [SELW-1:0]   mux_idx;
  logic [WIDTH-1:0]  dout_d;

  // Only a continuing scan counts dwell; entering scan or any manual edge restarts it.
  assign scan_live = (state_q == ST_SCAN) && (mode == MODE_SCAN);
  assign last_ch   = (ch_q == SELW'(CHANNELS - 1));

  dwell_counter #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en && scan_live),
    .clr   (en && !scan_live),
    .tick  (tick)
  );

  always_comb begin
    ch_d = '0;
    if (mode == MODE_MANUAL) begin
      ch_d = sel;
    end else if (scan_live) begin
      ch_d = tick ? (last_ch ? '0 : ch_q + 1'b1) : ch_q;
    end
  end

  // Explicit range check so non-power-of-two CHANNELS never reads past din.
  assign in_range = ({1'b0, ch_d} < (SELW + 1)'(CHANNELS));
  assign mux_idx  = in_range ? ch_d : '0;
  assign dout_d   = in_range ? din[mux_idx*WIDTH +: WIDTH] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_MANUAL;
      ch_q    <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else if (en) begin
      state_q <= (mode == MODE_SCAN) ? ST_SCAN : ST_MANUAL;
      ch_q    <= ch_d;
      dout_q  <= dout_d;
      valid_q <= in_range;
      wrap_q  <= scan_live && tick && last_ch;
    end
  end

  assign dout      = dout_q;
  assign ch        = ch_q;
  assign valid     = valid_q;
  assign wrap      = wrap_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mux_scan_n.sv
// Bench for mux_scan_n: a 4-channel/dwell-3 instance and a 3-channel/dwell-1 instance
// checked against a position-based reference model plus directed expectations.
module tb_mux_scan_n;
  import mux_scan_pkg::*;

  localparam int W  = 4;
  localparam int CA = 4;
  localparam int DA = 3;
  localparam int CB = 3;
  localparam int DB = 1;
  localparam logic [15:0] DIN_A = 16'hDCBA;
  localparam logic [15:0] DIN_B = 16'h0CBA;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [CA*W-1:0] din_a = '0;
  logic            mode_a = 1'b0;
  logic [1:0]      sel_a = '0;
  logic            en_a = 1'b0;
  logic [W-1:0]    dout_a;
  logic [1:0]      ch_a;
  logic            valid_a, wrap_a;
  state_e          st_a;

  logic [CB*W-1:0] din_b = '0;
  logic            mode_b = 1'b0;
  logic [1:0]      sel_b = '0;
  logic            en_b = 1'b0;
  logic [W-1:0]    dout_b;
  logic [1:0]      ch_b;
  logic            valid_b, wrap_b;
  state_e          st_b;

  mux_scan_n #(.WIDTH(W), .CHANNELS(CA), .DWELL(DA)) dut_a (
    .clk(clk), .rst_n(rst_n), .din(din_a), .mode(mode_a), .sel(sel_a), .en(en_a),
    .dout(dout_a), .ch(ch_a), .valid(valid_a), .wrap(wrap_a), .state_dbg(st_a)
  );

  mux_scan_n #(.WIDTH(W), .CHANNELS(CB), .DWELL(DB)) dut_b (
    .clk(clk), .rst_n(rst_n), .din(din_b), .mode(mode_b), .sel(sel_b), .en(en_b),
    .dout(dout_b), .ch(ch_b), .valid(valid_b), .wrap(wrap_b), .state_dbg(st_b)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // k = number of enabled scan edges since scan entry (-1 while manual).
  typedef struct packed {
    int         k;
    logic [3:0] dout;
    int         ch;
    logic       valid;
    logic       wrap;
  } model_t;

  localparam model_t MODEL_RST = '{k: -1, dout: 4'h0, ch: 0, valid: 1'b0, wrap: 1'b0};

  model_t ma = MODEL_RST;
  model_t mb = MODEL_RST;

  function automatic model_t model_edge(model_t s, int chans, int dwell, bit en, bit mode,
                                        int sel, logic [15:0] din);
    model_t n = s;
    if (!en) return s;
    n.wrap = 1'b0;
    if (!mode) begin
      n.k     = -1;
      n.ch    = sel;
      n.valid = (sel < chans);
      n.dout  = n.valid ? 4'((din >> (4 * sel)) & 16'hF) : 4'h0;
    end else begin
      n.k     = s.k + 1;
      n.ch    = (n.k / dwell) % chans;
      n.valid = 1'b1;
      n.wrap  = (n.k > 0) && ((n.k % (dwell * chans)) == 0);
      n.dout  = 4'((din >> (4 * n.ch)) & 16'hF);
    end
    return n;
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_a(bit en, bit mode, int sel, logic [15:0] din);
    en_a = en; mode_a = mode; sel_a = 2'(sel); din_a = din;
    @(posedge clk);
    ma = model_edge(ma, CA, DA, en, mode, sel, din);
    #1;
  endtask

  task automatic drive_b(bit en, bit mode, int sel, logic [15:0] din);
    en_b = en; mode_b = mode; sel_b = 2'(sel); din_b = din[11:0];
    @(posedge clk);
    mb = model_edge(mb, CB, DB, en, mode, sel, din);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({dout_a, ch_a, valid_a, wrap_a, st_a} !== {4'h0, 2'd0, 1'b0, 1'b0, ST_MANUAL}) begin
      errors++;
      $display("FAIL reset_a: got dout=%h ch=%0d valid=%b wrap=%b st=%0d, want all 0/MANUAL",
               dout_a, ch_a, valid_a, wrap_a, st_a);
    end
    checks++;
    if ({dout_b, ch_b, valid_b, wrap_b, st_b} !== {4'h0, 2'd0, 1'b0, 1'b0, ST_MANUAL}) begin
      errors++;
      $display("FAIL reset_b: got dout=%h ch=%0d valid=%b wrap=%b st=%0d, want all 0/MANUAL",
               dout_b, ch_b, valid_b, wrap_b, st_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ma = MODEL_RST;
    mb = MODEL_RST;
  endtask

  task automatic test_channels3();
    bit m = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive_b(1'b1, 1'b1, 0, DIN_B);
      checks++;
      if ({dout_b, ch_b, valid_b, wrap_b} !==
          {4'(4'hA + i % 3), 2'(i % 3), 1'b1, 1'((i > 0) && (i % 3 == 0))}) begin
        errors++;
        $display("FAIL c3_scan[%0d]: got dout=%h ch=%0d valid=%b wrap=%b, want ch=%0d wrap=%b",
                 i, dout_b, ch_b, valid_b, wrap_b, i % 3, (i > 0) && (i % 3 == 0));
      end
    end
    drive_b(1'b1, 1'b0, 3, DIN_B);
    checks++;
    if ({dout_b, ch_b, valid_b, wrap_b} !== {4'h0, 2'd3, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL c3_sel3: got dout=%h ch=%0d valid=%b wrap=%b, want dout=0 ch=3 valid=0 wrap=0",
               dout_b, ch_b, valid_b, wrap_b);
    end
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0) m = ~m;
      drive_b($urandom_range(0, 4) != 0, m, $urandom_range(0, 3), 16'($urandom));
      checks++;
      if ({dout_b, ch_b, valid_b, wrap_b} !== {mb.dout, 2'(mb.ch), mb.valid, mb.wrap}) begin
        errors++;
        $display("FAIL c3_rand[%0d]: got dout=%h ch=%0d valid=%b wrap=%b, want dout=%h ch=%0d valid=%b wrap=%b",
                 i, dout_b, ch_b, valid_b, wrap_b, mb.dout, mb.ch, mb.valid, mb.wrap);
      end
    end
    en_b = 1'b0;
  endtask

  task automatic test_manual();
    drive_a(1'b1, 1'b0, 2, DIN_A);
    checks++;
    if ({dout_a, ch_a, valid_a, wrap_a} !== {4'hC, 2'd2, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL manual_sel2: got dout=%h ch=%0d valid=%b wrap=%b, want C/2/1/0",
               dout_a, ch_a, valid_a, wrap_a);
    end
    drive_a(1'b1, 1'b0, 3, DIN_A);
    checks++;
    if ({dout_a, ch_a, valid_a} !== {4'hD, 2'd3, 1'b1}) begin
      errors++;
      $display("FAIL manual_sel3: got dout=%h ch=%0d valid=%b, want D/3/1", dout_a, ch_a, valid_a);
    end
    for (int i = 0; i < 16; i++) begin
      drive_a($urandom_range(0, 3) != 0, 1'b0, $urandom_range(0, 3), 16'($urandom));
      checks++;
      if ({dout_a, ch_a, valid_a, wrap_a} !== {ma.dout, 2'(ma.ch), ma.valid, ma.wrap}) begin
        errors++;
        $display("FAIL manual_rand[%0d]: got dout=%h ch=%0d valid=%b wrap=%b, want dout=%h ch=%0d valid=%b wrap=%b",
                 i, dout_a, ch_a, valid_a, wrap_a, ma.dout, ma.ch, ma.valid, ma.wrap);
      end
    end
  endtask

  task automatic test_scan_sequence();
    int seq [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
    drive_a(1'b1, 1'b0, 0, DIN_A);
    for (int i = 0; i < 13; i++) begin
      drive_a(1'b1, 1'b1, 0, DIN_A);
      checks++;
      if ({dout_a, ch_a, valid_a, wrap_a, st_a} !==
          {4'(4'hA + seq[i]), 2'(seq[i]), 1'b1, 1'(i == 12), ST_SCAN}) begin
        errors++;
        $display("FAIL scan_seq[%0d]: got dout=%h ch=%0d valid=%b wrap=%b st=%0d, want ch=%0d wrap=%b",
                 i, dout_a, ch_a, valid_a, wrap_a, st_a, seq[i], i == 12);
      end
    end
  endtask

  task automatic test_freeze();
    for (int i = 0; i < 40; i++) begin
      if (ma.ch == 2 && (ma.k % DA) == 1) break;
      drive_a(1'b1, 1'b1, 0, DIN_A);
    end
    checks++;
    if (ch_a !== 2'd2 || ma.ch != 2) begin
      errors++;
      $display("FAIL freeze_reach: got ch=%0d, want ch=2 with cnt=1", ch_a);
    end
    for (int i = 0; i < 5; i++) begin
      drive_a(1'b0, 1'($urandom), $urandom_range(0, 3), 16'($urandom));
      checks++;
      if ({dout_a, ch_a, valid_a, wrap_a} !== {ma.dout, 2'(ma.ch), ma.valid, ma.wrap}) begin
        errors++;
        $display("FAIL freeze_hold[%0d]: got dout=%h ch=%0d valid=%b wrap=%b, want dout=%h ch=%0d valid=%b wrap=%b",
                 i, dout_a, ch_a, valid_a, wrap_a, ma.dout, ma.ch, ma.valid, ma.wrap);
      end
    end
    drive_a(1'b1, 1'b1, 0, DIN_A);
    checks++;
    if ({dout_a, ch_a} !== {4'hC, 2'd2}) begin
      errors++;
      $display("FAIL freeze_resume1: got dout=%h ch=%0d, want C/2", dout_a, ch_a);
    end
    drive_a(1'b1, 1'b1, 0, DIN_A);
    checks++;
    if ({dout_a, ch_a} !== {4'hD, 2'd3}) begin
      errors++;
      $display("FAIL freeze_resume2: got dout=%h ch=%0d, want D/3", dout_a, ch_a);
    end
  endtask

  task automatic test_mode_toggle();
    for (int i = 0; i < 40; i++) begin
      if (ma.ch == 1 && (ma.k % DA) == 1) break;
      drive_a(1'b1, 1'b1, 0, DIN_A);
    end
    checks++;
    if (ch_a !== 2'd1 || ma.ch != 1) begin
      errors++;
      $display("FAIL toggle_reach: got ch=%0d, want ch=1 with cnt=1", ch_a);
    end
    drive_a(1'b1, 1'b0, 3, DIN_A);
    checks++;
    if ({dout_a, ch_a, valid_a, wrap_a, st_a} !== {4'hD, 2'd3, 1'b1, 1'b0, ST_MANUAL}) begin
      errors++;
      $display("FAIL toggle_manual: got dout=%h ch=%0d valid=%b wrap=%b st=%0d, want D/3/1/0/MANUAL",
               dout_a, ch_a, valid_a, wrap_a, st_a);
    end
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, 1'b1, 3, DIN_A);
      checks++;
      if ({dout_a, ch_a, wrap_a} !== {4'(i < 3 ? 4'hA : 4'hB), 2'(i < 3 ? 0 : 1), 1'b0}) begin
        errors++;
        $display("FAIL toggle_rescan[%0d]: got dout=%h ch=%0d wrap=%b, want ch=%0d wrap=0",
                 i, dout_a, ch_a, wrap_a, i < 3 ? 0 : 1);
      end
    end
  endtask

  task automatic test_random_a();
    bit m = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) m = ~m;
      drive_a($urandom_range(0, 4) != 0, m, $urandom_range(0, 3), 16'($urandom));
      checks++;
      if ({dout_a, ch_a, valid_a, wrap_a} !== {ma.dout, 2'(ma.ch), ma.valid, ma.wrap}) begin
        errors++;
        $display("FAIL rand_a[%0d]: got dout=%h ch=%0d valid=%b wrap=%b, want dout=%h ch=%0d valid=%b wrap=%b",
                 i, dout_a, ch_a, valid_a, wrap_a, ma.dout, ma.ch, ma.valid, ma.wrap);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 40; i++) begin
      if (ma.ch == 3 && ma.k >= 0) break;
      drive_a(1'b1, 1'b1, 0, DIN_A);
    end
    checks++;
    if (ch_a !== 2'd3 || st_a !== ST_SCAN) begin
      errors++;
      $display("FAIL areset_reach: got ch=%0d st=%0d, want ch=3 in SCAN", ch_a, st_a);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({dout_a, ch_a, valid_a, wrap_a, st_a} !== {4'h0, 2'd0, 1'b0, 1'b0, ST_MANUAL}) begin
      errors++;
      $display("FAIL areset_midcycle: got dout=%h ch=%0d valid=%b wrap=%b st=%0d, want all 0/MANUAL",
               dout_a, ch_a, valid_a, wrap_a, st_a);
    end
    #2 rst_n = 1'b1;
    ma = MODEL_RST;
    mb = MODEL_RST;
    drive_a(1'b1, 1'b0, 1, DIN_A);
    checks++;
    if ({dout_a, ch_a, valid_a, wrap_a} !== {4'hB, 2'd1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL areset_release: got dout=%h ch=%0d valid=%b wrap=%b, want B/1/1/0",
               dout_a, ch_a, valid_a, wrap_a);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_channels3();
    test_manual();
    test_scan_sequence();
    test_freeze();
    test_mode_toggle();
    test_random_a();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
